// File: rtl/sfm_pkg.sv
// Shared types and helpers for the FP reduction-sum controller.
package sfm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FEED,
    ST_DRAIN,
    ST_OUTPUT,
    ST_CLEAR
  } red_ctrl_state_e;

  localparam int unsigned STRB_MAX = 64;

  // Remainder-based form keeps num = 2^32-1 from wrapping.
  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num / den) + (((num % den) != 0) ? 32'd1 : 32'd0);
  endfunction

  function automatic logic [STRB_MAX-1:0] tail_strb(input int unsigned tail);
    if (tail == 0) return '1;
    return (STRB_MAX'(1) << tail) - STRB_MAX'(1);
  endfunction

endpackage

// File: rtl/sfm_red_sum_ctrl.sv
// Row-reduction job sequencer: splits a row into beats for the FP sum datapath,
// drains it, and returns the accumulated scalar on a valid/ready port.
module sfm_red_sum_ctrl
  import sfm_pkg::*;
#(
  parameter int unsigned VECT_WIDTH = 4,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter type         TAG_TYPE   = logic
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  TAG_TYPE               tag_i,
  output logic                  idle_o,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic                  dp_valid_o,
  output logic [VECT_WIDTH-1:0] dp_strb_o,
  input  logic                  dp_ready_i,
  output logic                  dp_enable_o,
  output logic                  dp_clear_o,
  input  logic                  dp_done_i,
  input  logic [ACC_WIDTH-1:0]  dp_res_i,
  input  logic                  dp_busy_i,
  output logic [ACC_WIDTH-1:0]  res_o,
  output TAG_TYPE               res_tag_o,
  output logic                  res_valid_o,
  input  logic                  res_ready_i
);

  localparam int unsigned TAIL_MASK = VECT_WIDTH - 1;

  red_ctrl_state_e       state_q, state_d;
  logic [LEN_WIDTH-1:0]  beats_left_q, beats_left_d;
  logic [LEN_WIDTH-1:0]  pending_q, pending_d;
  logic [VECT_WIDTH-1:0] last_strb_q, last_strb_d;
  TAG_TYPE               tag_q, tag_d;
  logic [ACC_WIDTH-1:0]  res_q, res_d;
  logic                  res_valid_q, res_valid_d;
  logic                  idle_q, idle_d;
  logic                  dp_enable_q, dp_enable_d;
  logic                  dp_clear_q, dp_clear_d;

  logic in_feed;
  logic xfer;
  logic accept;
  logic last_beat;

  assign in_feed   = (state_q == ST_FEED);
  assign xfer      = in_feed & in_valid_i & dp_ready_i;
  assign accept    = idle_q & start_i;
  assign last_beat = (beats_left_q == LEN_WIDTH'(1));

  assign in_ready_o  = in_feed & dp_ready_i;
  assign dp_valid_o  = in_feed & in_valid_i;
  assign dp_strb_o   = !in_feed ? '0 : (last_beat ? last_strb_q : '1);
  assign idle_o      = idle_q;
  assign dp_enable_o = dp_enable_q;
  assign dp_clear_o  = dp_clear_q;
  assign res_o       = res_q;
  assign res_tag_o   = tag_q;
  assign res_valid_o = res_valid_q;

  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    last_strb_d  = last_strb_q;
    tag_d        = tag_q;
    res_d        = res_q;
    res_valid_d  = res_valid_q;
    idle_d       = idle_q;
    dp_enable_d  = dp_enable_q;
    dp_clear_d   = 1'b0;

    pending_d = pending_q;
    if (xfer && !dp_done_i) begin
      pending_d = pending_q + LEN_WIDTH'(1);
    end else if (!xfer && dp_done_i && (pending_q != '0)) begin
      pending_d = pending_q - LEN_WIDTH'(1);
    end

    // idle_q is high in IDLE and in the post-reset CLEAR cycle, so a start
    // arriving in either is launched here rather than inside the case.
    if (accept) begin
      tag_d        = tag_i;
      beats_left_d = LEN_WIDTH'(ceil_div(32'(len_i), VECT_WIDTH));
      last_strb_d  = VECT_WIDTH'(tail_strb(32'(len_i) & TAIL_MASK));
      idle_d       = 1'b0;
      if (len_i == '0) begin
        res_d       = '0;
        res_valid_d = 1'b1;
        state_d     = ST_OUTPUT;
      end else begin
        dp_enable_d = 1'b1;
        state_d     = ST_FEED;
      end
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_FEED: begin
          if (xfer) begin
            beats_left_d = beats_left_q - LEN_WIDTH'(1);
            if (last_beat) state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if ((pending_q == '0) && !dp_busy_i) begin
            res_d       = dp_res_i;
            res_valid_d = 1'b1;
            dp_enable_d = 1'b0;
            state_d     = ST_OUTPUT;
          end
        end
        ST_OUTPUT: begin
          if (res_ready_i) begin
            res_valid_d = 1'b0;
            dp_clear_d  = 1'b1;
            state_d     = ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          idle_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: begin
          idle_d  = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end

    if (clear_i) begin
      state_d      = ST_CLEAR;
      beats_left_d = '0;
      pending_d    = '0;
      tag_d        = '0;
      res_d        = '0;
      res_valid_d  = 1'b0;
      idle_d       = 1'b0;
      dp_enable_d  = 1'b0;
      dp_clear_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_CLEAR;
      beats_left_q <= '0;
      pending_q    <= '0;
      last_strb_q  <= '0;
      tag_q        <= '0;
      res_q        <= '0;
      res_valid_q  <= 1'b0;
      idle_q       <= 1'b1;
      dp_enable_q  <= 1'b0;
      dp_clear_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      pending_q    <= pending_d;
      last_strb_q  <= last_strb_d;
      tag_q        <= tag_d;
      res_q        <= res_d;
      res_valid_q  <= res_valid_d;
      idle_q       <= idle_d;
      dp_enable_q  <= dp_enable_d;
      dp_clear_q   <= dp_clear_d;
    end
  end

  // A completion with nothing outstanding means the datapath and the counter disagree.
  a_done_without_pending: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (dp_done_i && !clear_i && ((state_q == ST_FEED) || (state_q == ST_DRAIN))) |-> (pending_q != '0)
  );

endmodule

// File: tb/tb_sfm_red_sum_ctrl.sv
// Bench for sfm_red_sum_ctrl: behavioural FP-sum datapath model, upstream beat
// source, scoreboard on the result port, table-driven jobs plus corner sequences.
module tb_sfm_red_sum_ctrl;

  localparam int VW = 4;
  localparam int AW = 32;
  localparam int LW = 16;
  typedef logic [3:0] tag_t;

  typedef struct packed {
    logic [31:0] res;
    tag_t        tag;
  } exp_t;

  typedef struct {
    int          len;
    tag_t        tag;
    logic [31:0] res;
    int          beats;
    logic [3:0]  last;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear_i, start_i;
  logic [LW-1:0] len_i;
  tag_t          tag_i;
  logic          idle_o;
  logic          in_valid_i, in_ready_o;
  logic          dp_valid_o;
  logic [VW-1:0] dp_strb_o;
  logic          dp_ready_i, dp_enable_o, dp_clear_o;
  logic          dp_done_i, dp_busy_i;
  logic [AW-1:0] dp_res_i, res_o;
  tag_t          res_tag_o;
  logic          res_valid_o, res_ready_i;

  always #5 clk = ~clk;

  sfm_red_sum_ctrl #(
    .VECT_WIDTH(VW),
    .ACC_WIDTH (AW),
    .LEN_WIDTH (LW),
    .TAG_TYPE  (tag_t)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clear_i    (clear_i),
    .start_i    (start_i),
    .len_i      (len_i),
    .tag_i      (tag_i),
    .idle_o     (idle_o),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .dp_valid_o (dp_valid_o),
    .dp_strb_o  (dp_strb_o),
    .dp_ready_i (dp_ready_i),
    .dp_enable_o(dp_enable_o),
    .dp_clear_o (dp_clear_o),
    .dp_done_i  (dp_done_i),
    .dp_res_i   (dp_res_i),
    .dp_busy_i  (dp_busy_i),
    .res_o      (res_o),
    .res_tag_o  (res_tag_o),
    .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Small non-negative integers to IEEE single precision.
  function automatic logic [31:0] f32(input longint v);
    int p;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 24; i++) if (((v >> i) & 1) != 0) p = i;
    m = 32'(v) << (23 - p);
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  function automatic int lane_sum(input int beat, input logic [3:0] strb, input int len);
    int s = 0;
    for (int j = 0; j < VW; j++)
      if (strb[j]) s += ((beat * VW + j) < len) ? 1 : 100;
    return s;
  endfunction

  // Datapath model: fixed-latency pipe into an integer accumulator.
  int         lat = 2;
  logic       pv[8];
  int         ps[8];
  longint     acc;
  int         beat_idx;
  int         cur_len = 0;
  int         up_beats = 0;
  int         beats_total = 0;
  logic [3:0] last_strb_seen = 4'h0;
  int         results_seen = 0;
  int         clear_pulses = 0;
  logic       bp = 1'b0;
  exp_t       sb[$];

  assign dp_done_i = pv[lat-1];
  assign dp_res_i  = f32(acc);

  always_comb begin
    dp_busy_i = 1'b0;
    for (int k = 0; k < 8; k++) if (k < lat && pv[k]) dp_busy_i = 1'b1;
  end

  always @(posedge clk) begin
    if (!rst_n || clear_i) begin
      for (int k = 0; k < 8; k++) pv[k] <= 1'b0;
    end else begin
      pv[0] <= dp_enable_o && dp_valid_o && dp_ready_i;
      ps[0] <= lane_sum(beat_idx, dp_strb_o, cur_len);
      for (int k = 1; k < 8; k++) begin
        pv[k] <= pv[k-1];
        ps[k] <= ps[k-1];
      end
    end
    if (!rst_n || dp_clear_o) acc <= 0;
    else if (dp_done_i)       acc <= acc + longint'(ps[lat-1]);
    if (!rst_n || (start_i && idle_o)) beat_idx <= 0;
    else if (in_valid_i && in_ready_o) beat_idx <= beat_idx + 1;
    if (dp_valid_o && dp_ready_i) begin
      beats_total    <= beats_total + 1;
      last_strb_seen <= dp_strb_o;
    end
  end

  // Upstream source and datapath ready, changed just after each edge.
  initial begin
    in_valid_i = 1'b0;
    dp_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      dp_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid_i = (beat_idx < up_beats) && (bp ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Monitor: per-beat strobe check and result scoreboard.
  initial begin
    int rem;
    logic [3:0] es;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (dp_valid_o && dp_ready_i) begin
          rem = cur_len - beat_idx * VW;
          if (rem >= VW)     es = 4'hF;
          else if (rem <= 0) es = 4'h0;
          else               es = 4'((1 << rem) - 1);
          chk("beat_strb", 64'(dp_strb_o), 64'(es));
        end
        if (res_valid_o && res_ready_i) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got res 0x%0h tag %0d, expected none", res_o, res_tag_o);
          end else begin
            e = sb.pop_front();
            chk("res", 64'(res_o), 64'(e.res));
            chk("res_tag", 64'(res_tag_o), 64'(e.tag));
          end
          results_seen++;
        end
        if (dp_clear_o) clear_pulses++;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_start(input int len, input tag_t tag);
    for (int i = 0; i < 100 && !idle_o; i++) begin
      @(posedge clk);
      #1;
    end
    if (!idle_o) fail_now("idle_wait");
    start_i = 1'b1;
    len_i   = LW'(len);
    tag_i   = tag;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic run_job(input vec_t v, output int n);
    int b0, r0, c0;
    b0 = beats_total;
    r0 = results_seen;
    c0 = clear_pulses;
    sb.push_back('{res: v.res, tag: v.tag});
    cur_len  = v.len;
    up_beats = (v.len + VW - 1) / VW;
    do_start(v.len, v.tag);
    n = 0;
    while (results_seen == r0 && n < 40000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (results_seen == r0) fail_now("result_wait");
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("beat_count", 64'(beats_total - b0), 64'(v.beats));
    if (v.beats > 0) chk("last_strb", 64'(last_strb_seen), 64'(v.last));
    chk("clear_pulse", 64'(clear_pulses - c0), 64'd1);
    chk("idle_after", 64'(idle_o), 64'd1);
  endtask

  vec_t tbl[8];

  initial begin
    int n, b0, r0, c0;
    vec_t v;

    tbl[0] = '{len: 8,     tag: 4'd1,  res: 32'h41000000, beats: 2,     last: 4'hF};
    tbl[1] = '{len: 6,     tag: 4'd2,  res: 32'h40C00000, beats: 2,     last: 4'h3};
    tbl[2] = '{len: 0,     tag: 4'd5,  res: 32'h00000000, beats: 0,     last: 4'h0};
    tbl[3] = '{len: 1,     tag: 4'd6,  res: 32'h3F800000, beats: 1,     last: 4'h1};
    tbl[4] = '{len: 5,     tag: 4'd7,  res: 32'h40A00000, beats: 2,     last: 4'h1};
    tbl[5] = '{len: 7,     tag: 4'd8,  res: 32'h40E00000, beats: 2,     last: 4'h7};
    tbl[6] = '{len: 4,     tag: 4'd9,  res: 32'h40800000, beats: 1,     last: 4'hF};
    tbl[7] = '{len: 65535, tag: 4'd10, res: 32'h477FFF00, beats: 16384, last: 4'h7};

    rst_n = 1'b0;
    clear_i = 1'b0;
    start_i = 1'b0;
    len_i = '0;
    tag_i = '0;
    res_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_idle", 64'(idle_o), 64'd1);
    chk("rst_res_valid", 64'(res_valid_o), 64'd0);
    chk("rst_dp_clear", 64'(dp_clear_o), 64'd0);
    chk("rst_dp_enable", 64'(dp_enable_o), 64'd0);
    chk("rst_in_ready", 64'(in_ready_o), 64'd0);
    chk("rst_dp_valid", 64'(dp_valid_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      run_job(tbl[i], n);
      if (tbl[i].len == 0) chk("len0_latency", 64'(n), 64'd1);
    end

    // Back-pressure on both sides, 37 elements.
    bp = 1'b1;
    v = '{len: 37, tag: 4'd11, res: 32'h42140000, beats: 10, last: 4'h1};
    run_job(v, n);
    bp = 1'b0;

    // Result held off for 10 cycles; a start in that window must be dropped.
    res_ready_i = 1'b0;
    b0 = beats_total;
    r0 = results_seen;
    sb.push_back('{res: 32'h40800000, tag: 4'd3});
    cur_len  = 4;
    up_beats = 1;
    do_start(4, 4'd3);
    n = 0;
    while (!res_valid_o && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!res_valid_o) fail_now("hold_valid_wait");
    for (int i = 0; i < 10; i++) begin
      start_i = (i == 3);
      len_i   = LW'(8);
      tag_i   = 4'd9;
      @(posedge clk);
      #1;
      chk("hold_valid", 64'(res_valid_o), 64'd1);
      chk("hold_res", 64'(res_o), 64'h40800000);
      chk("hold_tag", 64'(res_tag_o), 64'd3);
      chk("hold_idle", 64'(idle_o), 64'd0);
    end
    start_i = 1'b0;
    res_ready_i = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    chk("hold_results", 64'(results_seen - r0), 64'd1);
    chk("hold_no_requeue", 64'(beats_total - b0), 64'd1);
    chk("hold_idle_end", 64'(idle_o), 64'd1);

    // Abort in DRAIN with two beats still in a 4-deep datapath.
    lat = 4;
    b0 = beats_total;
    r0 = results_seen;
    c0 = clear_pulses;
    sb.push_back('{res: 32'h41000000, tag: 4'd4});
    cur_len  = 8;
    up_beats = 2;
    do_start(8, 4'd4);
    n = 0;
    while (beats_total != b0 + 2 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (beats_total != b0 + 2) fail_now("abort_beat_wait");
    chk("abort_in_drain", 64'(dp_enable_o && !in_ready_o), 64'd1);
    clear_i = 1'b1;
    @(posedge clk);
    #1;
    clear_i = 1'b0;
    void'(sb.pop_back());
    @(posedge clk);
    #1;
    chk("abort_idle", 64'(idle_o), 64'd1);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    chk("abort_clear_pulse", 64'(clear_pulses - c0), 64'd1);
    chk("abort_no_result", 64'(results_seen - r0), 64'd0);

    v = '{len: 6, tag: 4'd12, res: 32'h40C00000, beats: 2, last: 4'h3};
    run_job(v, n);
    lat = 2;
    v = '{len: 8, tag: 4'd13, res: 32'h41000000, beats: 2, last: 4'hF};
    run_job(v, n);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sfm_red_sum_ctrl.md
Name: sfm_red_sum_ctrl

Overview:
- Sequences one row-reduction job through the FP reduction-sum datapath (vector adder tree plus accumulator).
- Splits a row of LEN elements into VECT_WIDTH-wide beats and drives the datapath valid and strobe.
- Tracks outstanding beats through the datapath pipeline and drains it.
- Captures the final accumulated scalar, presents it on a valid/ready output, then clears the accumulator for the next row.

Parameters:
- VECT_WIDTH, 4, elements per beat; power of two, >= 1.
- ACC_WIDTH, 32, width of the accumulated result (ACC format).
- LEN_WIDTH, 16, width of the row-length field.
- TAG_TYPE, logic, job tag carried from start to result.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- clear_i  in  1  sync soft reset; aborts the job
- start_i  in  1  job request; accepted only when idle_o=1
- len_i  in  LEN_WIDTH  row length in elements; sampled on start accept
- tag_i  in  TAG_TYPE  job tag; sampled on start accept
- idle_o  out  1  controller in IDLE
- in_valid_i  in  1  upstream beat valid
- in_ready_o  out  1  upstream beat ready
- dp_valid_o  out  1  beat valid to datapath
- dp_strb_o  out  VECT_WIDTH  element strobe to datapath
- dp_ready_i  in  1  datapath ready_o
- dp_enable_o  out  1  datapath enable
- dp_clear_o  out  1  datapath accumulator clear
- dp_done_i  in  1  datapath valid_o; one pulse per completed beat
- dp_res_i  in  ACC_WIDTH  datapath running sum
- dp_busy_i  in  1  datapath busy_o
- res_o  out  ACC_WIDTH  final row sum
- res_tag_o  out  TAG_TYPE  tag of the job
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result ready

Behaviour:
- Reset and clear_i: all outputs 0 except idle_o=1; FSM goes to CLEAR for one cycle, then IDLE.
- States: IDLE, FEED, DRAIN, OUTPUT, CLEAR.
- IDLE
  - On start_i, latch the tag and beats_left = ceil(len_i/VECT_WIDTH).
  - Latch tail = len_i mod VECT_WIDTH.
  - len_i=0 → go to OUTPUT with res_o=0 (+0.0). Otherwise → FEED.
- FEED
  - in_ready_o = dp_ready_i; dp_valid_o = in_valid_i; dp_enable_o=1. Purely combinational pass-through, zero added latency.
  - A beat transfers when in_valid_i & dp_ready_i.
  - dp_strb_o is all ones, except on the last beat with tail≠0, where it is (1<<tail)-1.
  - Each transfer decrements beats_left and increments pending. A dp_done_i pulse decrements pending. Transfer and done in the same cycle leave pending unchanged.
  - After the last beat transfers → DRAIN.
- DRAIN
  - in_ready_o=0, dp_valid_o=0, dp_enable_o=1.
  - When pending=0 and dp_busy_i=0, capture res_o=dp_res_i → OUTPUT.
- OUTPUT
  - res_valid_o=1; res_o and res_tag_o stay stable until res_ready_i.
  - On handshake → CLEAR.
- CLEAR
  - dp_clear_o=1 for exactly one cycle, then IDLE.
- Latency: last beat accept → res_valid_o is datapath latency plus 1 cycle.
- Start while not idle is ignored and does not queue.
- clear_i has priority over every event, including a simultaneous handshake. A pending dp_done_i is discarded.
- Counter widths: pending uses LEN_WIDTH bits. A dp_done_i with pending=0 is an error; assertion only, counter saturates at 0.
- len_i=2^LEN_WIDTH-1 must not overflow the beat count.

Decomposition:
- sfm_pkg additions:
  - red_ctrl_state_e enum.
  - Helper function ceil_div for the beat count.
  - Helper function tail_strb(tail) returning the last-beat strobe.
- No sub-module needed.
- A top-level wrapper instantiates this block alongside sfm_fp_red_sum; the wrapper lives outside this block.

Test Plan:
- VECT_WIDTH=4, len=8, all-1.0 inputs, datapath latency 2 → two beats with strb 4'b1111, one res_valid_o with res_o=0x41000000 (8.0), then one dp_clear_o pulse.
- len=6 → beats with strb 4'b1111 then 4'b0011; the ignored lanes hold 100.0; res_o=6.0.
- len=0, tag=5 → no dp_valid_o, res_valid_o next cycle with res_o=0 and res_tag_o=5.
- res_ready_i low for 10 cycles → res_o stable; start_i in that window is ignored; idle_o=0.
- Random dp_ready_i back-pressure at 50%, len=37 → exactly 10 beats, final strb 4'b0001, result equals the golden model.
- clear_i asserted in DRAIN with pending=2 → idle_o=1 within 2 cycles, dp_clear_o pulses, no res_valid_o; the next job returns the correct sum.
